// File: rtl/halflife_sequencer.sv
// halflife_sequencer
//   Sequences a half-life decay run on an external up/down/load counter.
//   A run loads an initial count, then repeatedly waits a programmable
//   period and steps the counter down until its value has halved (floor).
//   The run ends with a one-cycle done pulse once a halving reaches zero.
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous active-low reset
//   start     in   1   begin a run (accepted only in IDLE)
//   abort     in   1   cancel; return to IDLE and clear the counter
//   init_val  in   N   initial count, captured on an accepted start
//   period    in   PW  cycles per half-life wait (0 behaves as 1)
//   cnt_val   in   N   counter output (registered, 1-cycle command latency)
//   cnt_clr   out  1   counter clear command
//   cnt_down  out  1   counter decrement command
//   cnt_load  out  1   counter load command
//   cnt_in    out  N   counter load data
//   busy      out  1   high while a run is in progress
//   done      out  1   one-cycle pulse at run completion
//   halvings  out  HW  completed halvings (saturating)
module halflife_sequencer #(
  parameter int N  = 4,
  parameter int PW = 8,
  parameter int HW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  init_val,
  input  logic [PW-1:0] period,
  input  logic [N-1:0]  cnt_val,
  output logic          cnt_clr,
  output logic          cnt_down,
  output logic          cnt_load,
  output logic [N-1:0]  cnt_in,
  output logic          busy,
  output logic          done,
  output logic [HW-1:0] halvings
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    WAIT  = 2'b10,
    HALVE = 2'b11
  } state_t;

  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [N-1:0]  N_ONE = N'(1);

  state_t        r_state;
  logic [PW-1:0] r_prescaler;
  logic [PW-1:0] r_period;
  logic [N-1:0]  r_target;
  logic [HW-1:0] r_halvings;
  logic          r_cnt_clr;
  logic          r_cnt_down;
  logic          r_cnt_load;
  logic [N-1:0]  r_cnt_in;
  logic          r_done;

  state_t        w_next_state;
  logic [PW-1:0] w_prescaler_next;
  logic [PW-1:0] w_period_next;
  logic [N-1:0]  w_target_next;
  logic [HW-1:0] w_halvings_next;
  logic          w_clr_next;
  logic          w_down_next;
  logic          w_load_next;
  logic [N-1:0]  w_cnt_in_next;
  logic          w_done_next;
  logic [PW-1:0] w_wait_last;
  logic [N-1:0]  w_cnt_pred;

  // Last prescaler value of a wait; a zero period behaves like one cycle.
  assign w_wait_last = (r_period == '0) ? '0 : (r_period - P_ONE);

  // Counter value expected after this cycle's edge, given the decrement
  // command currently being issued. Lets cnt_down stay a registered output
  // without stepping past the target.
  assign w_cnt_pred = r_cnt_down ? (cnt_val - N_ONE) : cnt_val;

  // Next-state and next-command logic. abort overrides everything,
  // including a start seen in the same cycle.
  always_comb begin
    w_next_state     = r_state;
    w_prescaler_next = r_prescaler;
    w_period_next    = r_period;
    w_target_next    = r_target;
    w_halvings_next  = r_halvings;
    w_clr_next       = 1'b0;
    w_load_next      = 1'b0;
    w_cnt_in_next    = '0;
    w_done_next      = 1'b0;

    if (abort) begin
      w_next_state = IDLE;
      w_clr_next   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_halvings_next = '0;
            if (init_val != '0) begin
              w_next_state  = LOAD;
              w_load_next   = 1'b1;
              w_cnt_in_next = init_val;
            end else begin
              w_done_next = 1'b1;
            end
          end
        end
        LOAD: begin
          w_next_state     = WAIT;
          w_prescaler_next = '0;
          w_period_next    = period;
        end
        WAIT: begin
          if (r_prescaler == w_wait_last) begin
            w_target_next = cnt_val >> 1;
            w_next_state  = HALVE;
          end else begin
            w_prescaler_next = r_prescaler + P_ONE;
          end
        end
        HALVE: begin
          if (cnt_val <= r_target) begin
            if (r_halvings != '1) begin
              w_halvings_next = r_halvings + H_ONE;
            end
            if (r_target == '0) begin
              w_next_state = IDLE;
              w_done_next  = 1'b1;
            end else begin
              w_next_state     = WAIT;
              w_prescaler_next = '0;
              w_period_next    = period;
            end
          end
        end
        default: w_next_state = IDLE;
      endcase
    end

    // Decrement next cycle only while the predicted value is above target.
    w_down_next = (w_next_state == HALVE) && (w_cnt_pred > w_target_next);
  end

  // State and registered command outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_prescaler <= '0;
      r_period    <= '0;
      r_target    <= '0;
      r_halvings  <= '0;
      r_cnt_clr   <= 1'b0;
      r_cnt_down  <= 1'b0;
      r_cnt_load  <= 1'b0;
      r_cnt_in    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_prescaler <= w_prescaler_next;
      r_period    <= w_period_next;
      r_target    <= w_target_next;
      r_halvings  <= w_halvings_next;
      r_cnt_clr   <= w_clr_next;
      r_cnt_down  <= w_down_next;
      r_cnt_load  <= w_load_next;
      r_cnt_in    <= w_cnt_in_next;
      r_done      <= w_done_next;
    end
  end

  assign cnt_clr  = r_cnt_clr;
  assign cnt_down = r_cnt_down;
  assign cnt_load = r_cnt_load;
  assign cnt_in   = r_cnt_in;
  assign done     = r_done;
  assign halvings = r_halvings;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_halflife_sequencer.sv
// tb_halflife_sequencer
//   Directed bench for halflife_sequencer with a behavioural model of the
//   external counter closing the loop on cnt_val.
module tb_halflife_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] init_val;
  logic [7:0] period;
  logic [3:0] cnt_val;
  logic       cnt_clr;
  logic       cnt_down;
  logic       cnt_load;
  logic [3:0] cnt_in;
  logic       busy;
  logic       done;
  logic [3:0] halvings;

  int vectors;
  int miscompares;
  int doneCount;
  int busyCount;
  int loadCount;
  int clrCount;
  logic prevDown;
  int seq[$];

  halflife_sequencer #(.N(4), .PW(8), .HW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .init_val (init_val),
    .period   (period),
    .cnt_val  (cnt_val),
    .cnt_clr  (cnt_clr),
    .cnt_down (cnt_down),
    .cnt_load (cnt_load),
    .cnt_in   (cnt_in),
    .busy     (busy),
    .done     (done),
    .halvings (halvings)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External counter: clear beats load beats decrement, one-cycle latency.
  initial cnt_val = 4'd0;
  always @(posedge clk) begin
    if (cnt_clr) cnt_val <= 4'd0;
    else if (cnt_load) cnt_val <= cnt_in;
    else if (cnt_down && cnt_val != 4'd0) cnt_val <= cnt_val - 4'd1;
  end

  // Activity monitor: counts pulses and records the value loaded plus the
  // value reached at the end of every decrement burst.
  initial prevDown = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (done) doneCount++;
      if (busy) busyCount++;
      if (cnt_load) begin
        loadCount++;
        seq.push_back(int'(cnt_in));
      end
      if (cnt_clr) clrCount++;
      if (prevDown && !cnt_down) seq.push_back(int'(cnt_val));
      prevDown = cnt_down;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearMonitors();
    doneCount = 0;
    busyCount = 0;
    loadCount = 0;
    clrCount  = 0;
    seq.delete();
  endtask

  task automatic applyStimulus(input logic s, input logic a,
                               input logic [3:0] iv, input logic [7:0] p);
    start    = s;
    abort    = a;
    init_val = iv;
    period   = p;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for the done pulse.
  task automatic waitDone(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      tick();
    end
    checkOutput({tag, "_done_seen"}, done, 1);
  endtask

  task automatic checkSeq(input string tag, input int exp[$]);
    checkOutput({tag, "_seq_len"}, seq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seq.size(); i++)
      checkOutput($sformatf("%s_seq%0d", tag, i), seq[i], exp[i]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clearMonitors();
    rst = 1'b0;
    applyStimulus(0, 0, 4'd0, 8'd0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_load", cnt_load, 0);
    checkOutput("rst_down", cnt_down, 0);
    checkOutput("rst_clr", cnt_clr, 0);
    checkOutput("rst_cnt_in", cnt_in, 0);
    checkOutput("rst_halvings", halvings, 0);
    rst = 1'b1;
    tick();

    // Test 1: 8 with period 4 -> 8,4,2,1,0
    clearMonitors();
    applyStimulus(1, 0, 4'd8, 8'd4);
    tick();
    checkOutput("t1_load", cnt_load, 1);
    checkOutput("t1_cnt_in", cnt_in, 8);
    checkOutput("t1_busy", busy, 1);
    applyStimulus(0, 0, 4'd8, 8'd4);
    waitDone("t1");
    checkOutput("t1_halvings", halvings, 4);
    checkOutput("t1_busy_end", busy, 0);
    tick();
    checkOutput("t1_done_drop", done, 0);
    checkOutput("t1_done_count", doneCount, 1);
    checkOutput("t1_busy_cycles", busyCount, 29);
    checkOutput("t1_load_count", loadCount, 1);
    checkSeq("t1", '{8, 4, 2, 1, 0});

    // Test 2: zero initial value
    clearMonitors();
    applyStimulus(1, 0, 4'd0, 8'd4);
    tick();
    applyStimulus(0, 0, 4'd0, 8'd4);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_busy", busy, 0);
    checkOutput("t2_load", cnt_load, 0);
    checkOutput("t2_halvings", halvings, 0);
    tick();
    checkOutput("t2_done_drop", done, 0);
    checkOutput("t2_done_count", doneCount, 1);
    checkOutput("t2_load_count", loadCount, 0);
    checkOutput("t2_busy_cycles", busyCount, 0);

    // Test 3: period 0, value 3 -> 3,1,0
    clearMonitors();
    applyStimulus(1, 0, 4'd3, 8'd0);
    tick();
    applyStimulus(0, 0, 4'd3, 8'd0);
    waitDone("t3");
    checkOutput("t3_halvings", halvings, 2);
    tick();
    checkOutput("t3_done_count", doneCount, 1);
    checkOutput("t3_busy_cycles", busyCount, 8);
    checkSeq("t3", '{3, 1, 0});

    // Test 4: abort in the second halving of an 8/period-4 run
    clearMonitors();
    applyStimulus(1, 0, 4'd8, 8'd4);
    tick();
    applyStimulus(0, 0, 4'd8, 8'd4);
    repeat (15) tick();
    checkOutput("t4_in_halve_down", cnt_down, 1);
    checkOutput("t4_pre_halvings", halvings, 1);
    checkOutput("t4_pre_busy", busy, 1);
    applyStimulus(0, 1, 4'd8, 8'd4);
    tick();
    applyStimulus(0, 0, 4'd8, 8'd4);
    checkOutput("t4_clr", cnt_clr, 1);
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_done", done, 0);
    checkOutput("t4_halvings", halvings, 1);
    tick();
    checkOutput("t4_clr_drop", cnt_clr, 0);
    checkOutput("t4_cnt_cleared", cnt_val, 0);
    repeat (5) tick();
    checkOutput("t4_no_done", doneCount, 0);
    checkOutput("t4_clr_count", clrCount, 1);
    checkOutput("t4_halvings_held", halvings, 1);

    // Test 5a: start held high while busy (with a different init_val)
    clearMonitors();
    applyStimulus(1, 0, 4'd2, 8'd2);
    tick();
    applyStimulus(1, 0, 4'd5, 8'd2);
    repeat (4) tick();
    applyStimulus(0, 0, 4'd5, 8'd2);
    waitDone("t5a");
    checkOutput("t5a_halvings", halvings, 2);
    tick();
    checkOutput("t5a_busy_cycles", busyCount, 9);
    checkOutput("t5a_load_count", loadCount, 1);
    checkOutput("t5a_done_count", doneCount, 1);

    // Test 5b: start and abort together in IDLE
    clearMonitors();
    applyStimulus(1, 1, 4'd5, 8'd2);
    tick();
    applyStimulus(0, 0, 4'd5, 8'd2);
    checkOutput("t5b_clr", cnt_clr, 1);
    checkOutput("t5b_load", cnt_load, 0);
    checkOutput("t5b_busy", busy, 0);
    tick();
    checkOutput("t5b_busy_after", busy, 0);
    checkOutput("t5b_load_count", loadCount, 0);
    checkOutput("t5b_done_count", doneCount, 0);

    // Test 6: reset in the second wait, then a fresh run 4 -> 2,1,0
    clearMonitors();
    applyStimulus(1, 0, 4'd8, 8'd4);
    tick();
    applyStimulus(0, 0, 4'd8, 8'd4);
    repeat (11) tick();
    checkOutput("t6_pre_busy", busy, 1);
    checkOutput("t6_pre_halvings", halvings, 1);
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_halvings", halvings, 0);
    checkOutput("t6_rst_down", cnt_down, 0);
    checkOutput("t6_rst_load", cnt_load, 0);
    checkOutput("t6_rst_clr", cnt_clr, 0);
    checkOutput("t6_rst_done", done, 0);
    tick();
    tick();
    checkOutput("t6_rst_hold_busy", busy, 0);
    rst = 1'b1;
    tick();
    clearMonitors();
    applyStimulus(1, 0, 4'd4, 8'd1);
    tick();
    applyStimulus(0, 0, 4'd4, 8'd1);
    checkOutput("t6_new_load", cnt_load, 1);
    checkOutput("t6_new_halvings0", halvings, 0);
    waitDone("t6");
    checkOutput("t6_halvings", halvings, 3);
    tick();
    checkOutput("t6_busy_cycles", busyCount, 11);
    checkOutput("t6_done_count", doneCount, 1);
    checkSeq("t6", '{4, 2, 1, 0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
